// File: rtl/d8m_debug_pkg.sv
// Shared definitions for the debug-monitor memory: FSM encoding, jdo field map
// and the default RAM depth.
package d8m_debug_pkg;

    localparam int MEM_WORDS_DFLT = 256;

    localparam int RDREQ    = 35;
    localparam int CLRERR   = 34;
    localparam int ADDR_HI  = 33;
    localparam int ADDR_LO  = 26;
    localparam int WDATA_HI = 34;
    localparam int WDATA_LO = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_e;

    typedef struct packed {
        logic        vld;
        cmd_e        cmd;
        logic [37:0] jdo;
    } slot_t;

endpackage

// File: rtl/d8m_debug_monitor_ram.sv
// Single-port monitor RAM, registered read (1-cycle latency), no reset so it
// maps onto a block RAM.
module d8m_debug_monitor_ram #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/d8m_debug_monitor_mem.sv
// Debug monitor memory: arbitrates JTAG monitor commands and CPU Avalon-MM
// accesses onto one single-port RAM through an IDLE/MEM/DONE sequencer.
module d8m_debug_monitor_mem
    import d8m_debug_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DFLT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [7:0]  cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    state_e      r_state, w_state_nxt;
    slot_t       r_slot;
    logic        r_own_cpu, r_we, r_ld_d, r_ready, r_error;
    logic [7:0]  r_addr, r_mon_a;
    logic [31:0] r_wdata, r_mon_d;
    logic [31:0] w_ram_rdata;
    cmd_e        w_cmd;
    logic        w_strobe, w_cpu_req, w_idle, w_disp_jtag, w_disp_cpu;
    logic        w_slot_free, w_drop, w_jtag_mem, w_ram_we, w_clr_err;
    logic        w_unused_jdo;

    assign w_unused_jdo = ^{r_slot.jdo[37:36], r_slot.jdo[2:0]};

    always_comb begin
        w_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        w_cmd       = take_action_ocimem_a ? CMD_LOAD :
                      (take_action_ocimem_b ? CMD_WRITE : CMD_READ);
        w_cpu_req   = cpu_read | cpu_write;
        w_idle      = (r_state == ST_IDLE);
        w_disp_jtag = w_idle & r_slot.vld;
        // A strobe arriving this cycle already outranks the CPU, so the CPU waits.
        w_disp_cpu  = w_idle & ~r_slot.vld & ~w_strobe & w_cpu_req;
        w_slot_free = ~r_slot.vld | w_disp_jtag;
        w_drop      = w_strobe & ~w_slot_free;
        w_jtag_mem  = w_disp_jtag & ((r_slot.cmd != CMD_LOAD) | r_slot.jdo[RDREQ]);
        w_clr_err   = w_disp_jtag & (r_slot.cmd == CMD_LOAD) & r_slot.jdo[CLRERR];
        w_ram_we    = (r_state == ST_MEM) & r_we;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_jtag_mem || w_disp_cpu) w_state_nxt = ST_MEM;
            ST_MEM:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot    <= '0;
            r_own_cpu <= 1'b0;
            r_we      <= 1'b0;
            r_ld_d    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mon_a   <= '0;
            r_mon_d   <= '0;
            r_ready   <= 1'b1;
            r_error   <= 1'b0;
        end else begin
            if (w_strobe && w_slot_free) begin
                r_slot.vld <= 1'b1;
                r_slot.cmd <= w_cmd;
                r_slot.jdo <= jdo;
            end else if (w_disp_jtag) begin
                r_slot.vld <= 1'b0;
            end

            if (w_drop)         r_error <= 1'b1;
            else if (w_clr_err) r_error <= 1'b0;

            if (w_disp_jtag) begin
                r_own_cpu <= 1'b0;
                case (r_slot.cmd)
                    CMD_LOAD: begin
                        r_mon_a <= r_slot.jdo[ADDR_HI:ADDR_LO];
                        r_addr  <= r_slot.jdo[ADDR_HI:ADDR_LO];
                        r_we    <= 1'b0;
                        r_ld_d  <= r_slot.jdo[RDREQ];
                        r_ready <= ~r_slot.jdo[RDREQ];
                    end
                    CMD_WRITE: begin
                        r_addr  <= r_mon_a;
                        r_wdata <= r_slot.jdo[WDATA_HI:WDATA_LO];
                        r_we    <= 1'b1;
                        r_ld_d  <= 1'b0;
                        r_mon_a <= r_mon_a + 8'd1;
                        r_ready <= 1'b0;
                    end
                    default: begin
                        r_addr  <= r_mon_a;
                        r_we    <= 1'b0;
                        r_ld_d  <= 1'b1;
                        r_mon_a <= r_mon_a + 8'd1;
                        r_ready <= 1'b0;
                    end
                endcase
            end else if (w_disp_cpu) begin
                r_own_cpu <= 1'b1;
                r_addr    <= cpu_address;
                r_wdata   <= cpu_writedata;
                r_we      <= cpu_write;
                r_ld_d    <= 1'b0;
            end else if (r_state == ST_DONE && !r_own_cpu) begin
                r_ready <= 1'b1;
                if (r_ld_d) r_mon_d <= w_ram_rdata;
            end
        end
    end

    d8m_debug_monitor_ram #(.WORDS(MEM_WORDS)) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign cpu_waitrequest = w_cpu_req & ((r_state != ST_DONE) | ~r_own_cpu);
    assign cpu_readdata    = (r_state == ST_DONE && r_own_cpu && !r_we) ? w_ram_rdata : 32'd0;
    assign MonDReg         = r_mon_d;
    assign monitor_ready   = r_ready;
    assign monitor_error   = r_error;

endmodule

// File: tb/tb_d8m_debug_monitor_mem.sv
// Bench for the debug monitor memory: word-array model of the RAM plus the
// monitor address pointer, randomized JTAG/CPU traffic.
module tb_d8m_debug_monitor_mem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata, MonDReg;
    logic        cpu_waitrequest, monitor_ready, monitor_error;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl_mem [256];
    logic [7:0]  wr_q [$];
    int          mdl_a;
    logic [31:0] mdl_d;

    always #5 clk = ~clk;

    d8m_debug_monitor_mem dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drives a strobe during the current cycle N; returns 1ns into cycle N+1.
    task automatic strobe(input int kind, input logic [37:0] d);
        jdo = d; ta_a = (kind == 0); ta_b = (kind == 1); tna_a = (kind == 2);
        step();
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] d;
        d = '0; d[35] = rd; d[34] = clr; d[33:26] = a;
        strobe(0, d);
    endtask

    task automatic jtag_write(input logic [31:0] v);
        logic [37:0] d;
        d = '0; d[34:3] = v;
        strobe(1, d);
    endtask

    task automatic cpu_xfer(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [31:0] wd, output logic [31:0] rdata, output int lat);
        cpu_address = a; cpu_read = rd; cpu_write = wr; cpu_writedata = wd;
        lat = -1; rdata = '0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (!cpu_waitrequest) begin rdata = cpu_readdata; lat = c; break; end
            step();
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", monitor_ready); end
        checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
        checks++; if (MonDReg !== 32'd0) begin failures++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
        checks++; if (cpu_readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", cpu_readdata); end
        checks++; if (cpu_waitrequest !== 1'b0) begin failures++; $display("FAIL reset_waitreq_idle got=%b exp=0", cpu_waitrequest); end
        cpu_read = 1'b1; #1;
        checks++; if (cpu_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_waitreq_req got=%b exp=1", cpu_waitrequest); end
        cpu_read = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mdl_a = 0; mdl_d = '0;
    endtask

    task automatic test_load_no_read();
        jtag_load(8'h10, 1'b0, 1'b0);
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL load_ready_n1 got=%b exp=1", monitor_ready); end
        step();
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL load_ready_n2 got=%b exp=1", monitor_ready); end
        idle(2);
        checks++; if (MonDReg !== mdl_d) begin failures++; $display("FAIL load_mondreg got=%h exp=%h", MonDReg, mdl_d); end
        mdl_a = 8'h10;
    endtask

    task automatic test_write_read();
        logic [31:0] r;
        int lat;
        jtag_write(32'hDEADBEEF);
        mdl_mem[mdl_a] = 32'hDEADBEEF; wr_q.push_back(8'(mdl_a)); mdl_a = (mdl_a + 1) % 256;
        idle(4);
        cpu_xfer(1'b1, 1'b0, 8'h10, '0, r, lat);
        checks++; if (r !== 32'hDEADBEEF || lat != 2) begin failures++; $display("FAIL wr_cpu_check got=%h lat=%0d exp=deadbeef lat=2", r, lat); end
        jtag_load(8'h10, 1'b1, 1'b0);
        checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL rd_ready_n1 got=%b exp=1", monitor_ready); end
        step();
        checks++; if (monitor_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_n2 got=%b exp=0", monitor_ready); end
        step();
        checks++; if (monitor_ready !== 1'b0 || MonDReg !== mdl_d) begin failures++; $display("FAIL rd_n3 ready=%b d=%h exp ready=0 d=%h", monitor_ready, MonDReg, mdl_d); end
        step();
        checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_n4 ready=%b d=%h exp ready=1 d=deadbeef", monitor_ready, MonDReg); end
        mdl_d = 32'hDEADBEEF; mdl_a = 8'h10;
        idle(1);
    endtask

    task automatic test_wrap();
        logic [31:0] va, vb, r;
        int lat;
        va = $urandom; vb = $urandom;
        jtag_load(8'hFF, 1'b0, 1'b0); idle(3); mdl_a = 255;
        jtag_write(va); idle(4);
        mdl_mem[mdl_a] = va; wr_q.push_back(8'(mdl_a)); mdl_a = (mdl_a + 1) % 256;
        jtag_write(vb); idle(4);
        mdl_mem[mdl_a] = vb; wr_q.push_back(8'(mdl_a)); mdl_a = (mdl_a + 1) % 256;
        cpu_xfer(1'b1, 1'b0, 8'h00, '0, r, lat);
        checks++; if (r !== mdl_mem[0] || lat != 2) begin failures++; $display("FAIL wrap_cpu_rd0 got=%h lat=%0d exp=%h lat=2", r, lat, mdl_mem[0]); end
        jtag_load(8'hFF, 1'b1, 1'b0); idle(3);
        checks++; if (MonDReg !== mdl_mem[255]) begin failures++; $display("FAIL wrap_memff got=%h exp=%h", MonDReg, mdl_mem[255]); end
        mdl_a = 255; idle(1);
        strobe(2, '0); idle(3);
        checks++; if (MonDReg !== mdl_mem[mdl_a]) begin failures++; $display("FAIL wrap_nact_ff got=%h exp=%h", MonDReg, mdl_mem[mdl_a]); end
        mdl_a = (mdl_a + 1) % 256; idle(1);
        strobe(2, '0); idle(3);
        checks++; if (MonDReg !== mdl_mem[mdl_a]) begin failures++; $display("FAIL wrap_nact_00 got=%h exp=%h", MonDReg, mdl_mem[mdl_a]); end
        mdl_a = (mdl_a + 1) % 256; idle(1);
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [31:0] v, r;
        int op, lat;
        logic rw;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 4);
            a = 8'($urandom); v = $urandom;
            if (op >= 2) a = wr_q[$urandom_range(0, wr_q.size() - 1)];
            case (op)
                0: begin
                    jtag_load(a, 1'b0, 1'b0); idle(3);
                    jtag_write(v); idle(4);
                    mdl_mem[a] = v; wr_q.push_back(a); mdl_a = (int'(a) + 1) % 256;
                end
                1: begin
                    rw = 1'($urandom_range(0, 1));
                    cpu_xfer(rw, 1'b1, a, v, r, lat);
                    checks++; if (lat != 2) begin failures++; $display("FAIL rnd_cpu_wr_lat got=%0d exp=2", lat); end
                    mdl_mem[a] = v; wr_q.push_back(a);
                end
                2: begin
                    cpu_xfer(1'b1, 1'b0, a, '0, r, lat);
                    checks++; if (r !== mdl_mem[a] || lat != 2) begin failures++; $display("FAIL rnd_cpu_rd a=%h got=%h lat=%0d exp=%h lat=2", a, r, lat, mdl_mem[a]); end
                end
                3: begin
                    jtag_load(a, 1'b1, 1'b0); idle(3);
                    checks++; if (MonDReg !== mdl_mem[a] || monitor_ready !== 1'b1) begin failures++; $display("FAIL rnd_jtag_rd a=%h got=%h rdy=%b exp=%h rdy=1", a, MonDReg, monitor_ready, mdl_mem[a]); end
                    mdl_a = a; idle(1);
                end
                default: begin
                    jtag_load(a, 1'b0, 1'b0); idle(3);
                    strobe(2, '0); idle(3);
                    checks++; if (MonDReg !== mdl_mem[a]) begin failures++; $display("FAIL rnd_nact_rd a=%h got=%h exp=%h", a, MonDReg, mdl_mem[a]); end
                    mdl_a = (int'(a) + 1) % 256; idle(1);
                end
            endcase
        end
    endtask

    task automatic test_back_to_back();
        strobe(2, '0);
        strobe(2, '0);
        checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL b2b_err_second got=%b exp=0", monitor_error); end
        strobe(2, '0);
        checks++; if (monitor_error !== 1'b1) begin failures++; $display("FAIL b2b_err_third got=%b exp=1", monitor_error); end
        idle(10);
        checks++; if (monitor_error !== 1'b1) begin failures++; $display("FAIL b2b_err_sticky got=%b exp=1", monitor_error); end
        jtag_load(8'h00, 1'b0, 1'b1);
        checks++; if (monitor_error !== 1'b1) begin failures++; $display("FAIL clr_err_n1 got=%b exp=1", monitor_error); end
        step();
        checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL clr_err_n2 got=%b exp=0", monitor_error); end
        mdl_a = 0; idle(2);
    endtask

    task automatic test_contention();
        logic [31:0] vold, vnew, r;
        logic [37:0] d;
        int lat;
        vold = $urandom; vnew = ~vold;
        cpu_xfer(1'b0, 1'b1, 8'd5, vold, r, lat);
        jtag_load(8'd5, 1'b0, 1'b0); idle(3);
        d = '0; d[34:3] = vnew;
        jdo = d; ta_b = 1'b1;
        cpu_address = 8'd5; cpu_read = 1'b1;
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) ta_b = 1'b0;
            #1;
            if (!cpu_waitrequest) begin r = cpu_readdata; lat = c; break; end
            @(posedge clk); #1;
        end
        ta_b = 1'b0; cpu_read = 1'b0;
        step();
        checks++; if (lat < 5) begin failures++; $display("FAIL contend_latency got=%0d exp>=5", lat); end
        checks++; if (r !== vnew) begin failures++; $display("FAIL contend_data got=%h exp=%h", r, vnew); end
        mdl_mem[5] = vnew; mdl_a = 6; idle(2);
    endtask

    task automatic test_reset_midop();
        logic [31:0] vold, vnew, r;
        int lat;
        vold = $urandom; vnew = ~vold;
        cpu_xfer(1'b0, 1'b1, 8'd3, vold, r, lat);
        strobe(2, '0); strobe(2, '0); strobe(2, '0); idle(10);
        jtag_load(8'd3, 1'b1, 1'b0); idle(4);
        checks++; if (monitor_error !== 1'b1 || MonDReg !== vold) begin failures++; $display("FAIL midop_pre err=%b d=%h exp err=1 d=%h", monitor_error, MonDReg, vold); end
        jtag_write(vnew);
        step();
        checks++; if (monitor_ready !== 1'b0) begin failures++; $display("FAIL midop_busy got=%b exp=0", monitor_ready); end
        reset_n = 1'b0; #1;
        checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin failures++; $display("FAIL midop_rst_status rdy=%b err=%b exp 1/0", monitor_ready, monitor_error); end
        checks++; if (MonDReg !== 32'd0 || cpu_readdata !== 32'd0 || cpu_waitrequest !== 1'b0) begin failures++; $display("FAIL midop_rst_data d=%h rd=%h wr=%b exp 0/0/0", MonDReg, cpu_readdata, cpu_waitrequest); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        mdl_a = 0; mdl_d = '0;
        cpu_xfer(1'b1, 1'b0, 8'd3, '0, r, lat);
        checks++; if (r !== vold || lat != 2) begin failures++; $display("FAIL midop_old_data got=%h lat=%0d exp=%h lat=2", r, lat, vold); end
    endtask

    initial begin
        test_reset();
        test_load_no_read();
        test_write_read();
        test_wrap();
        test_random();
        test_back_to_back();
        test_contention();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
